// File: rtl/processor_pkg.sv
// Shared encodings for the single-cycle RV64I core: opcodes, funct3 codes,
// ALU operation and writeback-source enums.
package processor_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_LOAD, WB_LINK
    } wb_sel_e;

    // Map funct3 plus the alternate bit (inst[30]) onto an ALU operation.
    function automatic alu_op_e alu_base_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/processor_regfile.sv
// 32 x 64-bit register file: two combinational reads, one write per clock,
// asynchronous clear, x0 pinned to zero.
module processor_regfile
    import processor_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [63:0] rd1,
    output logic [63:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [63:0] wd
);

    logic [63:0] regs_q [32];
    logic [63:0] regs_d [32];

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];

    // Next register contents: apply the write, then force x0 back to zero.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = 64'd0;
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 64'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/processor.sv
// Single-cycle RV64I core: decode, immediates, ALU, branch/jump, and
// load/store byte-lane handling. Only pc and the register file hold state.
module processor
    import processor_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] addr,
    output logic        wr_en,
    output logic [63:0] wdata,
    output logic [7:0]  wmask,
    input  logic [63:0] rdata
);

    logic [6:0]  opcode_s, f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [63:0] imm_i_s, imm_u_s;
    logic [31:0] imm_s_s, imm_b_s, imm_j_s;
    logic [63:0] rs1_val_s, rs2_val_s;
    logic [31:0] pc_q, pc_d, jalr_tgt_s, ls_addr_s;
    alu_op_e     alu_op_s;
    wb_sel_e     wb_sel_s;
    logic [63:0] alu_a_s, alu_b_s, alu_y_s, rf_wd_s, ld_shift_s, ld_val_s;
    logic        rf_we_s, is_load_s, is_store_s, br_taken_s;
    logic [2:0]  ls_off_s;
    logic [7:0]  st_size_mask_s;

    assign opcode_s = inst[6:0];
    assign rd_s     = inst[11:7];
    assign f3_s     = inst[14:12];
    assign rs1_s    = inst[19:15];
    assign rs2_s    = inst[24:20];
    assign f7_s     = inst[31:25];

    assign imm_i_s = {{52{inst[31]}}, inst[31:20]};
    assign imm_s_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u_s = {{32{inst[31]}}, inst[31:12], 12'd0};
    assign imm_j_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    processor_regfile u_regfile (
        .clk  (clk),
        .nrst (nrst),
        .ra1  (rs1_s),
        .ra2  (rs2_s),
        .rd1  (rs1_val_s),
        .rd2  (rs2_val_s),
        .we   (rf_we_s),
        .wa   (rd_s),
        .wd   (rf_wd_s)
    );

    // Store immediate only for stores; loads use the I-format offset.
    assign ls_addr_s  = rs1_val_s[31:0] + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s[31:0]);
    assign ls_off_s   = ls_addr_s[2:0];
    assign jalr_tgt_s = (rs1_val_s[31:0] + imm_i_s[31:0]) & 32'hFFFF_FFFE;

    // Branch condition evaluation; reserved funct3 codes never branch.
    always_comb begin
        br_taken_s = 1'b0;
        case (f3_s)
            F3_BEQ:  br_taken_s = (rs1_val_s == rs2_val_s);
            F3_BNE:  br_taken_s = (rs1_val_s != rs2_val_s);
            F3_BLT:  br_taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            F3_BGE:  br_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            F3_BLTU: br_taken_s = (rs1_val_s < rs2_val_s);
            F3_BGEU: br_taken_s = (rs1_val_s >= rs2_val_s);
            default: br_taken_s = 1'b0;
        endcase
    end

    // Main decode: operand selection, register write, memory intent, next PC.
    // Unrecognised encodings fall through with every enable low (NOP).
    always_comb begin
        alu_op_s   = ALU_ADD;
        alu_a_s    = rs1_val_s;
        alu_b_s    = imm_i_s;
        rf_we_s    = 1'b0;
        wb_sel_s   = WB_ALU;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        pc_d       = pc_q + 32'd4;
        case (opcode_s)
            OPC_LUI: begin
                rf_we_s  = 1'b1;
                alu_op_s = ALU_PASS_B;
                alu_b_s  = imm_u_s;
            end
            OPC_AUIPC: begin
                rf_we_s = 1'b1;
                alu_a_s = {32'd0, pc_q};
                alu_b_s = imm_u_s;
            end
            OPC_JAL: begin
                rf_we_s  = 1'b1;
                wb_sel_s = WB_LINK;
                pc_d     = pc_q + imm_j_s;
            end
            OPC_JALR: begin
                if (f3_s == 3'b000) begin
                    rf_we_s  = 1'b1;
                    wb_sel_s = WB_LINK;
                    pc_d     = jalr_tgt_s;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if (br_taken_s) begin
                    pc_d = pc_q + imm_b_s;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            OPC_LOAD: begin
                if (f3_s != 3'b111) begin
                    is_load_s = 1'b1;
                    rf_we_s   = 1'b1;
                    wb_sel_s  = WB_LOAD;
                end else begin
                    is_load_s = 1'b0;
                end
            end
            OPC_STORE: begin
                if (!f3_s[2]) begin
                    is_store_s = 1'b1;
                end else begin
                    is_store_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                alu_op_s = alu_base_op(f3_s, (f3_s == F3_SR) && inst[30]);
                if (f3_s == F3_SLL) begin
                    rf_we_s = (inst[31:26] == 6'b000000);
                end else if (f3_s == F3_SR) begin
                    rf_we_s = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
                end else begin
                    rf_we_s = 1'b1;
                end
            end
            OPC_OP: begin
                alu_b_s  = rs2_val_s;
                alu_op_s = alu_base_op(f3_s, f7_s[5]);
                if (f7_s == 7'b0000000) begin
                    rf_we_s = 1'b1;
                end else if ((f7_s == 7'b0100000) && ((f3_s == F3_ADD) || (f3_s == F3_SR))) begin
                    rf_we_s = 1'b1;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            default: rf_we_s = 1'b0;
        endcase
    end

    // 64-bit ALU; shifts use the low six bits of operand b.
    always_comb begin
        alu_y_s = 64'd0;
        case (alu_op_s)
            ALU_ADD:    alu_y_s = alu_a_s + alu_b_s;
            ALU_SUB:    alu_y_s = alu_a_s - alu_b_s;
            ALU_SLL:    alu_y_s = alu_a_s << alu_b_s[5:0];
            ALU_SLT:    alu_y_s = {63'd0, ($signed(alu_a_s) < $signed(alu_b_s))};
            ALU_SLTU:   alu_y_s = {63'd0, (alu_a_s < alu_b_s)};
            ALU_XOR:    alu_y_s = alu_a_s ^ alu_b_s;
            ALU_SRL:    alu_y_s = alu_a_s >> alu_b_s[5:0];
            ALU_SRA:    alu_y_s = $signed(alu_a_s) >>> alu_b_s[5:0];
            ALU_OR:     alu_y_s = alu_a_s | alu_b_s;
            ALU_AND:    alu_y_s = alu_a_s & alu_b_s;
            ALU_PASS_B: alu_y_s = alu_b_s;
            default:    alu_y_s = 64'd0;
        endcase
    end

    assign ld_shift_s = rdata >> {ls_off_s, 3'b000};

    // Load data: align the addressed lane to bit 0, then extend.
    always_comb begin
        ld_val_s = ld_shift_s;
        case (f3_s)
            F3_LB:   ld_val_s = {{56{ld_shift_s[7]}}, ld_shift_s[7:0]};
            F3_LH:   ld_val_s = {{48{ld_shift_s[15]}}, ld_shift_s[15:0]};
            F3_LW:   ld_val_s = {{32{ld_shift_s[31]}}, ld_shift_s[31:0]};
            F3_LD:   ld_val_s = ld_shift_s;
            F3_LBU:  ld_val_s = {56'd0, ld_shift_s[7:0]};
            F3_LHU:  ld_val_s = {48'd0, ld_shift_s[15:0]};
            F3_LWU:  ld_val_s = {32'd0, ld_shift_s[31:0]};
            default: ld_val_s = ld_shift_s;
        endcase
    end

    // Writeback source select.
    always_comb begin
        rf_wd_s = alu_y_s;
        case (wb_sel_s)
            WB_ALU:  rf_wd_s = alu_y_s;
            WB_LOAD: rf_wd_s = ld_val_s;
            WB_LINK: rf_wd_s = {32'd0, pc_q + 32'd4};
            default: rf_wd_s = alu_y_s;
        endcase
    end

    // Store lane enables by access size before shifting to the byte offset.
    always_comb begin
        st_size_mask_s = 8'hFF;
        case (f3_s[1:0])
            SZ_B:    st_size_mask_s = 8'h01;
            SZ_H:    st_size_mask_s = 8'h03;
            SZ_W:    st_size_mask_s = 8'h0F;
            default: st_size_mask_s = 8'hFF;
        endcase
    end

    // Strobes are gated by reset so a store in flight cannot commit.
    assign wr_en = is_store_s && nrst;
    assign wmask = (is_store_s && nrst) ? (st_size_mask_s << ls_off_s) : 8'h00;
    assign wdata = rs2_val_s << {ls_off_s, 3'b000};
    assign addr  = (is_load_s || is_store_s) ? ls_addr_s : 32'd0;
    assign pc    = pc_q;

    // Program counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_processor.sv
// Directed self-checking bench for the processor core with a small
// 64-bit-word byte-masked data memory.
module tb_processor;
    import processor_pkg::*;

    logic        clk, nrst;
    logic [31:0] inst, pc, addr;
    logic        wr_en;
    logic [63:0] wdata, rdata;
    logic [7:0]  wmask;
    logic [63:0] mem [64];
    logic [31:0] exp_pc;
    logic [63:0] v;
    int          checks, errors;

    localparam logic [63:0] PAT0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PAT1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] PAT2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] X5V  = 64'h8877_6655_4433_2211;

    processor dut (
        .clk   (clk),
        .nrst  (nrst),
        .inst  (inst),
        .pc    (pc),
        .addr  (addr),
        .wr_en (wr_en),
        .wdata (wdata),
        .wmask (wmask),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata = mem[addr[8:3]];

    always @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask[i]) mem[addr[8:3]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Execute one instruction across a rising edge; leave a NOP on the bus.
    task automatic step(input logic [31:0] ins);
        inst = ins;
        @(posedge clk);
        #1;
        inst = 32'd0;
    endtask

    // Observe a register through the store-data path without clocking.
    task automatic peek(input logic [4:0] r, output logic [63:0] val);
        inst = enc_s(12'h000, r, 5'd0, 3'b011);
        #1;
        val = wdata;
        inst = 32'd0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        inst = enc_s(12'h000, 5'd1, 5'd0, 3'b011);
        #2;
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wmask !== 8'h00) begin errors++; $display("FAIL reset_wmask got %h exp 00", wmask); end
        @(posedge clk); #2;
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_hold_pc got %h exp 0", pc); end
        nrst = 1'b1;
        peek(5'd1, v);
        checks++; if (v !== 64'd0) begin errors++; $display("FAIL reset_x1 got %h exp 0", v); end
        exp_pc = 32'd0;
    endtask

    task automatic test_arith();
        logic [31:0] prog [4];
        logic [63:0] exp_x1 [4];
        prog[0] = enc_i(12'd3, 5'd1, 3'b000, 5'd1, OPC_OP_IMM);
        prog[1] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd1, OPC_OP_IMM);
        prog[2] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd1);
        prog[3] = enc_r(7'h20, 5'd1, 5'd1, 3'b000, 5'd1);
        exp_x1 = '{64'd3, 64'd2, 64'd4, 64'd0};
        for (int k = 0; k < 4; k++) begin
            step(prog[k]);
            exp_pc = exp_pc + 32'd4;
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL arith_pc[%0d] got %h exp %h", k, pc, exp_pc); end
            peek(5'd1, v);
            checks++; if (v !== exp_x1[k]) begin errors++; $display("FAIL arith_x1[%0d] got %h exp %h", k, v, exp_x1[k]); end
        end
        step(32'd0);
        exp_pc = exp_pc + 32'd4;
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL nop_pc got %h exp 14", pc); end
        step(enc_j(21'h1FFFF4, 5'd2));
        exp_pc = 32'h8;
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL jal_pc got %h exp 8", pc); end
        peek(5'd2, v);
        checks++; if (v !== 64'h18) begin errors++; $display("FAIL jal_link got %h exp 18", v); end
    endtask

    task automatic test_branch();
        logic [2:0] bf3 [8];
        logic [4:0] brs1 [8];
        logic [4:0] brs2 [8];
        logic       btk [8];
        step(enc_b(13'h1FFC, 5'd0, 5'd1, 3'b000));
        exp_pc = 32'h4;
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL beq_taken_pc got %h exp 4", pc); end
        step(enc_b(13'h1FFC, 5'd0, 5'd1, 3'b001));
        exp_pc = 32'h8;
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL bne_not_pc got %h exp 8", pc); end
        step(enc_i(12'hFFF, 5'd0, 3'b000, 5'd6, OPC_OP_IMM));
        step(enc_i(12'h001, 5'd0, 3'b000, 5'd7, OPC_OP_IMM));
        exp_pc = 32'h10;
        bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd6};
        brs1 = '{5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd7, 5'd7};
        brs2 = '{5'd6, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd6, 5'd6};
        btk  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            step(enc_b(13'h0010, brs2[k], brs1[k], bf3[k]));
            exp_pc = btk[k] ? exp_pc + 32'd16 : exp_pc + 32'd4;
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL branch[%0d] f3=%0d pc got %h exp %h", k, bf3[k], pc, exp_pc); end
        end
        v = {32'd0, exp_pc + 32'd4};
        step(enc_i(12'h005, 5'd2, 3'b000, 5'd12, OPC_JALR));
        exp_pc = 32'h1C;
        checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL jalr_pc got %h exp 1c", pc); end
        begin
            logic [63:0] link;
            link = v;
            peek(5'd12, v);
            checks++; if (v !== link) begin errors++; $display("FAIL jalr_link got %h exp %h", v, link); end
        end
    endtask

    task automatic test_mem();
        logic [63:0] pats [3];
        pats = '{PAT0, PAT1, PAT2};
        for (int k = 0; k < 3; k++) begin
            inst = enc_i(12'(8 * k), 5'd0, 3'b011, 5'd3, OPC_LOAD);
            #1;
            checks++; if (addr !== 32'(8 * k) || wr_en !== 1'b0) begin errors++; $display("FAIL ld_addr[%0d] got %h/%b exp %h/0", k, addr, wr_en, 8 * k); end
            step(inst);
            exp_pc = exp_pc + 32'd4;
            peek(5'd3, v);
            checks++; if (v !== pats[k]) begin errors++; $display("FAIL ld_data[%0d] got %h exp %h", k, v, pats[k]); end
        end
        inst = enc_s(12'd32, 5'd3, 5'd0, 3'b011);
        #1;
        checks++; if (addr !== 32'h20) begin errors++; $display("FAIL sd_addr got %h exp 20", addr); end
        checks++; if (wr_en !== 1'b1 || wmask !== 8'hFF) begin errors++; $display("FAIL sd_strobe got %b/%h exp 1/ff", wr_en, wmask); end
        checks++; if (wdata !== PAT2) begin errors++; $display("FAIL sd_wdata got %h exp %h", wdata, PAT2); end
        step(inst);
        exp_pc = exp_pc + 32'd4;
        checks++; if (mem[4] !== PAT2) begin errors++; $display("FAIL sd_mem got %h exp %h", mem[4], PAT2); end
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL sd_pc got %h exp %h", pc, exp_pc); end
    endtask

    task automatic test_lanes();
        logic [31:0] lins [4];
        logic [4:0]  lrd [4];
        logic [63:0] lexp [4];
        step(enc_i(12'd40, 5'd0, 3'b011, 5'd5, OPC_LOAD));
        inst = enc_s(12'd3, 5'd5, 5'd0, 3'b000);
        #1;
        checks++; if (wmask !== 8'h08) begin errors++; $display("FAIL sb_wmask got %h exp 08", wmask); end
        checks++; if (wdata !== 64'h5544_3322_1100_0000) begin errors++; $display("FAIL sb_wdata got %h exp 5544332211000000", wdata); end
        step(inst);
        inst = enc_s(12'd6, 5'd5, 5'd0, 3'b001);
        #1;
        checks++; if (wmask !== 8'hC0) begin errors++; $display("FAIL sh_wmask got %h exp c0", wmask); end
        checks++; if (wdata !== 64'h2211_0000_0000_0000) begin errors++; $display("FAIL sh_wdata got %h exp 2211000000000000", wdata); end
        step(inst);
        checks++; if (mem[0] !== 64'h2211_4567_11AB_CDEF) begin errors++; $display("FAIL sub_word_mem got %h exp 2211456711abcdef", mem[0]); end
        lins[0] = enc_i(12'd50, 5'd0, 3'b000, 5'd8, OPC_LOAD);
        lins[1] = enc_i(12'd50, 5'd0, 3'b100, 5'd9, OPC_LOAD);
        lins[2] = enc_i(12'd46, 5'd0, 3'b001, 5'd10, OPC_LOAD);
        lins[3] = enc_i(12'd44, 5'd0, 3'b110, 5'd11, OPC_LOAD);
        lrd  = '{5'd8, 5'd9, 5'd10, 5'd11};
        lexp = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_8877, 64'h8877_6655};
        for (int k = 0; k < 4; k++) begin
            step(lins[k]);
            peek(lrd[k], v);
            checks++; if (v !== lexp[k]) begin errors++; $display("FAIL load_ext[%0d] got %h exp %h", k, v, lexp[k]); end
        end
        exp_pc = exp_pc + 32'd28;
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL lanes_pc got %h exp %h", pc, exp_pc); end
    endtask

    task automatic test_alu();
        logic [31:0] ains [10];
        logic [4:0]  ard [10];
        logic [63:0] aexp [10];
        ains[0] = enc_r(7'h00, 5'd6, 5'd7, 3'b011, 5'd13);
        ains[1] = enc_r(7'h00, 5'd7, 5'd6, 3'b010, 5'd14);
        ains[2] = enc_i(12'h408, 5'd5, 3'b101, 5'd15, OPC_OP_IMM);
        ains[3] = enc_i(12'h008, 5'd5, 3'b101, 5'd16, OPC_OP_IMM);
        ains[4] = enc_i(12'h03F, 5'd7, 3'b001, 5'd17, OPC_OP_IMM);
        ains[5] = enc_i(12'h0F0, 5'd5, 3'b111, 5'd18, OPC_OP_IMM);
        ains[6] = enc_i(12'h800, 5'd0, 3'b110, 5'd19, OPC_OP_IMM);
        ains[7] = {20'h80000, 5'd20, OPC_LUI};
        ains[8] = enc_r(7'h20, 5'd7, 5'd5, 3'b101, 5'd21);
        ains[9] = enc_r(7'h20, 5'd6, 5'd7, 3'b000, 5'd22);
        ard  = '{5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22};
        aexp = '{64'd1, 64'd1, 64'hFF88_7766_5544_3322, 64'h0088_7766_5544_3322,
                 64'h8000_0000_0000_0000, 64'h10, 64'hFFFF_FFFF_FFFF_F800,
                 64'hFFFF_FFFF_8000_0000, 64'hC43B_B32A_A219_9108, 64'd2};
        for (int k = 0; k < 10; k++) begin
            step(ains[k]);
            exp_pc = exp_pc + 32'd4;
            peek(ard[k], v);
            checks++; if (v !== aexp[k]) begin errors++; $display("FAIL alu[%0d] got %h exp %h", k, v, aexp[k]); end
        end
    endtask

    task automatic test_nop_x0();
        step(32'd0);
        exp_pc = exp_pc + 32'd4;
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL nop2_pc got %h exp %h", pc, exp_pc); end
        peek(5'd5, v);
        checks++; if (v !== X5V) begin errors++; $display("FAIL nop_x5 got %h exp %h", v, X5V); end
        step(enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPC_OP_IMM));
        peek(5'd0, v);
        checks++; if (v !== 64'd0) begin errors++; $display("FAIL x0_write got %h exp 0", v); end
        step(enc_r(7'h01, 5'd7, 5'd7, 3'b000, 5'd23));
        exp_pc = exp_pc + 32'd8;
        peek(5'd23, v);
        checks++; if (v !== 64'd0 || pc !== exp_pc) begin errors++; $display("FAIL illegal_op got %h pc %h exp 0 pc %h", v, pc, exp_pc); end
    endtask

    task automatic test_reset_midrun();
        inst = enc_s(12'd8, 5'd5, 5'd0, 3'b011);
        #1;
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mid_pre_wr_en got %b exp 1", wr_en); end
        nrst = 1'b0;
        #1;
        checks++; if (pc !== 32'd0 || wr_en !== 1'b0 || wmask !== 8'h00) begin errors++; $display("FAIL mid_reset got pc %h we %b mask %h exp 0", pc, wr_en, wmask); end
        peek(5'd5, v);
        checks++; if (v !== 64'd0) begin errors++; $display("FAIL mid_reset_x5 got %h exp 0", v); end
        inst = enc_s(12'd8, 5'd5, 5'd0, 3'b011);
        @(posedge clk); #1;
        checks++; if (mem[1] !== PAT1) begin errors++; $display("FAIL mid_reset_mem got %h exp %h", mem[1], PAT1); end
        inst = 32'd0;
        nrst = 1'b1;
        step(enc_i(12'd7, 5'd0, 3'b000, 5'd1, OPC_OP_IMM));
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc got %h exp 4", pc); end
        peek(5'd1, v);
        checks++; if (v !== 64'd7) begin errors++; $display("FAIL post_reset_x1 got %h exp 7", v); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        inst = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        mem[0] = PAT0;
        mem[1] = PAT1;
        mem[2] = PAT2;
        mem[5] = X5V;
        mem[6] = 64'h0000_0000_0080_0000;
        test_reset();
        test_arith();
        test_branch();
        test_mem();
        test_lanes();
        test_alu();
        test_nop_x0();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor.md
# processor

Single-cycle RV64I integer core that executes one externally supplied 32-bit instruction per clock. It drives a 32-bit program counter to an instruction source and a 64-bit byte-masked data port. The data port connects to a 64-bit-word data memory (`mem_model`, word address = `addr[31:3]`, combinational read, synchronous masked write). It is the compute block of the COE133 RISC-V system.

## Interface
- No parameters. XLEN is 64, PC width is 32, there are 32 registers.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `nrst` in 1: reset; asynchronous, active-low.
- `inst` in 32: instruction at `pc`; combinational, must be stable before the rising edge.
- `pc` out 32: current program counter (registered).
- `addr` out 32: data byte address, `rs1 + sext(imm)` truncated to 32 bits; driven for loads and stores, 0 otherwise.
- `wr_en` out 1: store strobe; high only while a store executes.
- `wdata` out 64: store data, placed in its byte lanes.
- `wmask` out 8: byte-lane enables; bit i covers `wdata[8i+7:8i]`. 0 when not storing.
- `rdata` in 64: word read at `addr[31:3]`, same cycle, combinational.

## Operation
- Registers x0..x31 are 64 bits. x0 reads 0 and writes to it are discarded.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LD, LBU, LHU, LWU.
  - SB, SH, SW, SD.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (6-bit shamt).
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Any other encoding, including 0x00000000, is a NOP: no register write, no store, `pc += 4`.
- Immediates use the standard I/S/B/U/J formats, sign-extended to 64 bits. B and J immediates have LSB 0.
- Next PC:
  - Taken branch: `pc + imm`.
  - JAL: `pc + imm`.
  - JALR: `(rs1 + imm) & ~1`.
  - Everything else: `pc + 4`.
  - Arithmetic is 32-bit and wraps.
- JAL and JALR write `rd = zext(pc + 4)`.
- Loads: let `off = addr[2:0]`. Select the byte/half/word/dword from `rdata` starting at lane `off`, then sign- or zero-extend into `rd`.
- Stores:
  - `wmask` = 0x01, 0x03, 0x0F or 0xFF for SB, SH, SW or SD, shifted left by `off`.
  - `wdata` = rs2 shifted left by `8*off`.
  - Lanes beyond byte 7 are dropped. Misaligned accesses do not trap.
- There is no exception, interrupt or CSR logic.

## Timing
- Execution is single cycle. Decode, ALU, address, load-data selection and `wr_en`/`wmask`/`wdata` are combinational from `inst`, `pc`, register reads and `rdata`.
- On each rising edge with `nrst` high, `pc` and the `rd` write update together. The memory commits a store on the same edge.
- Reads see pre-edge register values. An instruction with rs1 == rd reads the old value.
- While `nrst` is low:
  - `pc` = 0 and all registers = 0.
  - `wr_en` = 0 and `wmask` = 0.
- Asserting `nrst` mid-operation clears state immediately. A store in flight at that moment must not commit, because `wr_en` is forced low.
- Deassertion is effective at the first rising edge after `nrst` goes high. The first executed instruction is the one at `pc` = 0.

## Structure
- Package `processor_pkg`:
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - funct3 constants for branches, loads/stores and ALU.
  - ALU-operation enum.
- Sub-module `processor_regfile`:
  - 32x64, two combinational read ports, one synchronous write port.
  - Async active-low clear; x0 hardwired to 0.
- The ALU, immediate generator and load/store lane logic stay in `processor`.

## Test plan
- Reset, then execute in order `addi x1,x1,3`; `addi x1,x1,-1`; `add x1,x1,x1`; `sub x1,x1,x1`. Expect x1 = 3, 2, 4, 0 and `pc` = 0x4, 0x8, 0xC, 0x10. Then `jal x2,-12` at `pc` 0x14 -> x2 = 0x18, `pc` = 0x8.
- `beq x1,x0,-4` with x1 = 0 at `pc` 0x8 -> `pc` = 0x4. Then `bne x1,x0,-4` -> not taken, `pc` = 0x8. Cover every branch funct3 with signed and unsigned boundary operands (-1 vs 1).
- Memory words 0, 1, 2 preloaded with distinct patterns. `ld x3,0(x0)`, `ld x3,8(x0)`, `ld x3,16(x0)` -> x3 equals each word in turn, `wr_en` = 0. Then `sd x3,32(x0)` -> `addr` = 0x20, `wr_en` = 1, `wmask` = 0xFF, `wdata` = x3, memory word 4 updated after the edge.
- x5 = 0x8877665544332211. `sb x5,3(x0)` -> `wmask` = 0x08, `wdata[31:24]` = 0x11. `sh x5,6(x0)` -> `wmask` = 0xC0. Then `lb`/`lbu` of a 0x80 byte -> 0xFFFF_FFFF_FFFF_FF80 / 0x80.
- `inst` = 0 (NOP) -> no register or memory change, `pc += 4`. Write to x0 -> x0 still reads 0.
- Drop `nrst` low mid-run during a store cycle -> `pc`, registers and `wmask` go to 0 immediately, `wr_en` is 0, memory is unchanged.
